// File: rtl/uart_cmd_pkg.sv
// -----------------------------------------------------------------------------
// uart_cmd_pkg
// Shared types and constants for the UART command parser.
//   state_e       : parser FSM states
//   SYNC..NAK     : frame and reply byte constants
//   frame_chk_ok  : checksum rule for a received frame (CHK = CMD ^ ADDR ^ DATA)
// -----------------------------------------------------------------------------
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GET_CMD   = 3'd1,
    GET_ADDR  = 3'd2,
    GET_DATA  = 3'd3,
    GET_CHK   = 3'd4,
    EXEC      = 3'd5,
    READ_WAIT = 3'd6,
    RESP      = 3'd7
  } state_e;

  localparam logic [7:0] SYNC   = 8'hA5;
  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;

  function automatic logic frame_chk_ok(input logic [7:0] cmd,
                                        input logic [7:0] addr,
                                        input logic [7:0] data,
                                        input logic [7:0] chk);
    return (cmd ^ addr ^ data) == chk;
  endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// -----------------------------------------------------------------------------
// uart_cmd_parser_if
// Bundles every non-clock signal of the UART command parser.
//   Receiver side    : REC_BYTE, RECEIVED
//   Register port    : WR_EN, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA
//   Transmitter side : TX_BYTE, TX_VALID, TX_READY
//   Status           : BUSY, ERR_COUNT (only with UART_CMD_PARSER_ERRCNT_EN)
// modport master : the parser itself (drives strobes, addresses, reply)
// modport slave  : the surrounding receiver / register file / transmitter
// -----------------------------------------------------------------------------
interface uart_cmd_parser_if #(
  parameter int unsigned ADDR_W = 8
) ();

  logic [7:0]        REC_BYTE;
  logic              RECEIVED;
  logic              WR_EN;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [7:0]        WR_DATA;
  logic [ADDR_W-1:0] RD_ADDR;
  logic [7:0]        RD_DATA;
  logic [7:0]        TX_BYTE;
  logic              TX_VALID;
  logic              TX_READY;
  logic              BUSY;
`ifdef UART_CMD_PARSER_ERRCNT_EN
  logic [7:0]        ERR_COUNT;
`endif

  modport master (
    input  REC_BYTE, RECEIVED, RD_DATA, TX_READY,
    output WR_EN, WR_ADDR, WR_DATA, RD_ADDR, TX_BYTE, TX_VALID, BUSY
`ifdef UART_CMD_PARSER_ERRCNT_EN
    , output ERR_COUNT
`endif
  );

  modport slave (
    output REC_BYTE, RECEIVED, RD_DATA, TX_READY,
    input  WR_EN, WR_ADDR, WR_DATA, RD_ADDR, TX_BYTE, TX_VALID, BUSY
`ifdef UART_CMD_PARSER_ERRCNT_EN
    , input ERR_COUNT
`endif
  );

endinterface

// File: rtl/uart_cmd_timeout.sv
// -----------------------------------------------------------------------------
// uart_cmd_timeout
// Inter-byte watchdog for the command parser.
//   iCE_CLK, RST_N : clock, asynchronous active-low reset
//   i_clr          : restart the count (a byte arrived / frame started)
//   i_en           : count this cycle (parser is collecting a frame)
//   o_expire       : one-cycle pulse when TIMEOUT_CYCLES idle cycles elapsed
// A clear in the same cycle as expiry suppresses the pulse, so a byte that
// arrives exactly at the limit is still accepted.
// -----------------------------------------------------------------------------
module uart_cmd_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1200000
) (
  input  logic iCE_CLK,
  input  logic RST_N,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned     CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] r_cnt;

  assign o_expire = i_en && !i_clr && (r_cnt == CNT_MAX);

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge iCE_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= '0;
    end else if (i_clr || o_expire) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// uart_cmd_parser
// Assembles 5-byte frames (SYNC CMD ADDR DATA CHK) from the UART receiver,
// performs a debug register write or read, and returns a one-byte reply
// (ACK, NAK or read data) to the UART transmitter.
//   iCE_CLK : system clock
//   RST_N   : asynchronous active-low reset
//   bus     : uart_cmd_parser_if.master (receiver, register port, transmitter,
//             BUSY, and ERR_COUNT when enabled)
// Parameters:
//   TIMEOUT_CYCLES : max idle cycles between frame bytes before abort
//   ADDR_W         : register address width, low bits of the ADDR byte
// Optional feature macro: UART_CMD_PARSER_ERRCNT_EN adds a saturating error
// counter (NAKs + timeouts) on ERR_COUNT, cleared by a write to address 0xFF.
// -----------------------------------------------------------------------------
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1200000,
  parameter int unsigned ADDR_W         = 8
) (
  input  logic              iCE_CLK,
  input  logic              RST_N,
  uart_cmd_parser_if.master bus
);

  logic       r_rx_d;
  logic       w_rx_evt;
  state_e     r_state;
  state_e     w_state_nxt;
  logic [7:0] r_cmd;
  logic [7:0] r_addr;
  logic [7:0] r_data;
  logic [7:0] r_chk;
  logic [7:0] r_reply;
  logic [7:0] w_reply_nxt;
  logic       w_reply_load;
  logic       w_wr_en;
  logic       w_tx_valid;
  logic       w_to_en;
  logic       w_expire;
  logic       w_frame_ok;

  // Only the rising edge of RECEIVED counts, so a long strobe is one byte.
  assign w_rx_evt = bus.RECEIVED && !r_rx_d;

  assign w_frame_ok = ((r_cmd == CMD_WR) || (r_cmd == CMD_RD)) &&
                      frame_chk_ok(r_cmd, r_addr, r_data, r_chk);

  assign w_to_en = (r_state == GET_CMD) || (r_state == GET_ADDR) ||
                   (r_state == GET_DATA) || (r_state == GET_CHK);

  // Entry to GET_CMD is itself an rx_evt, so clearing on every byte event
  // also covers the frame start.
  uart_cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .iCE_CLK (iCE_CLK),
    .RST_N   (RST_N),
    .i_clr   (w_rx_evt),
    .i_en    (w_to_en),
    .o_expire(w_expire)
  );

  always_ff @(posedge iCE_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_rx_d  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rx_d  <= bus.RECEIVED;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    w_state_nxt  = r_state;
    w_wr_en      = 1'b0;
    w_tx_valid   = 1'b0;
    w_reply_load = 1'b0;
    w_reply_nxt  = r_reply;
    case (r_state)
      IDLE: begin
        if (w_rx_evt && (bus.REC_BYTE == SYNC)) w_state_nxt = GET_CMD;
      end
      GET_CMD: begin
        if (w_rx_evt)      w_state_nxt = GET_ADDR;
        else if (w_expire) w_state_nxt = IDLE;
      end
      GET_ADDR: begin
        if (w_rx_evt)      w_state_nxt = GET_DATA;
        else if (w_expire) w_state_nxt = IDLE;
      end
      GET_DATA: begin
        if (w_rx_evt)      w_state_nxt = GET_CHK;
        else if (w_expire) w_state_nxt = IDLE;
      end
      GET_CHK: begin
        if (w_rx_evt)      w_state_nxt = EXEC;
        else if (w_expire) w_state_nxt = IDLE;
      end
      EXEC: begin
        if (!w_frame_ok) begin
          w_reply_load = 1'b1;
          w_reply_nxt  = NAK;
          w_state_nxt  = RESP;
        end else if (r_cmd == CMD_WR) begin
          w_wr_en      = 1'b1;
          w_reply_load = 1'b1;
          w_reply_nxt  = ACK;
          w_state_nxt  = RESP;
        end else begin
          w_state_nxt  = READ_WAIT;
        end
      end
      READ_WAIT: begin
        // RD_ADDR has been stable since EXEC, so RD_DATA is valid now.
        w_reply_load = 1'b1;
        w_reply_nxt  = bus.RD_DATA;
        w_state_nxt  = RESP;
      end
      RESP: begin
        w_tx_valid = 1'b1;
        if (bus.TX_READY) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Frame fields and reply; bytes arriving outside GET_* fall through.
  always_ff @(posedge iCE_CLK or negedge RST_N) begin
    if (!RST_N) begin
      // NOTE: these registers drive WR_ADDR/WR_DATA/RD_ADDR directly, so they
      // are reset to give zero outputs out of reset, not left as don't-care.
      r_cmd   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_chk   <= '0;
      r_reply <= '0;
    end else begin
      if (w_rx_evt) begin
        case (r_state)
          GET_CMD:  r_cmd  <= bus.REC_BYTE;
          GET_ADDR: r_addr <= bus.REC_BYTE;
          GET_DATA: r_data <= bus.REC_BYTE;
          GET_CHK:  r_chk  <= bus.REC_BYTE;
          default:  ;
        endcase
      end
      if (w_reply_load) r_reply <= w_reply_nxt;
    end
  end

  assign bus.WR_EN    = w_wr_en;
  assign bus.WR_ADDR  = r_addr[ADDR_W-1:0];
  assign bus.WR_DATA  = r_data;
  assign bus.RD_ADDR  = r_addr[ADDR_W-1:0];
  assign bus.TX_VALID = w_tx_valid;
  assign bus.TX_BYTE  = w_tx_valid ? r_reply : 8'h00;
  assign bus.BUSY     = (r_state != IDLE);

`ifdef UART_CMD_PARSER_ERRCNT_EN
  logic [7:0] r_err_cnt;
  logic       w_err_inc;
  logic       w_err_clr;

  assign w_err_inc = ((r_state == EXEC) && !w_frame_ok) || w_expire;
  // The full ADDR byte is compared so a narrow ADDR_W cannot alias onto it.
  assign w_err_clr = w_wr_en && (r_addr == 8'hFF);

  always_ff @(posedge iCE_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_err_cnt <= '0;
    end else if (w_err_clr) begin
      r_err_cnt <= '0;
    end else if (w_err_inc && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign bus.ERR_COUNT = r_err_cnt;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_parser
// Self-checking bench for uart_cmd_parser. A frame-level reference model
// (byte queue + gap counter + reply/stage bookkeeping) predicts every output
// each cycle; directed frames pin the model with hand-computed literals, then
// randomized frames, gaps, strobe widths and TX_READY stress the DUT.
// -----------------------------------------------------------------------------
module tb_uart_cmd_parser;

  localparam int unsigned TO = 100;
  localparam int unsigned AW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  bit   bp_hold = 1'b0;

  always #5 clk = ~clk;

  uart_cmd_parser_if #(.ADDR_W(AW)) bus ();

  uart_cmd_parser #(
    .TIMEOUT_CYCLES(TO),
    .ADDR_W        (AW)
  ) dut (
    .iCE_CLK(clk),
    .RST_N  (rst_n),
    .bus    (bus)
  );

  // Register file contents seen by reads: a fixed function of the address.
  function automatic logic [7:0] reg_val(input logic [7:0] a);
    return a ^ 8'hBB;
  endfunction

  assign bus.RD_DATA = reg_val(8'(bus.RD_ADDR));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit         m_prev;
  logic [7:0] m_q[$];      // bytes of the frame in progress, SYNC included
  int         m_gap;       // idle cycles since the last accepted byte
  int         m_post;      // 1: cycle after CHK, 2: second cycle of a read
  bit         m_resp;
  logic [7:0] m_reply;
  logic [7:0] m_last_reply;
`ifdef UART_CMD_PARSER_ERRCNT_EN
  int         m_err;
`endif

  // Observations of the DUT, used by the literal checks.
  int         wr_seen = 0;
  logic [7:0] last_wr_addr, last_wr_data;
  logic [7:0] tx_log[$];

  function automatic bit m_frame_ok();
    if (m_q.size() != 5) return 1'b0;
    if (m_q[1] != 8'h57 && m_q[1] != 8'h52) return 1'b0;
    return (m_q[1] ^ m_q[2] ^ m_q[3]) == m_q[4];
  endfunction

  function automatic void m_start_reply(input logic [7:0] r);
    m_reply      = r;
    m_last_reply = r;
    m_resp       = 1'b1;
    m_post       = 0;
    m_q.delete();
  endfunction

  always @(negedge clk) begin
    logic evt;
    logic exp_wr;
    if (!rst_n) begin
      check("rst_WR_EN", bus.WR_EN, 0);
      check("rst_WR_ADDR", bus.WR_ADDR, 0);
      check("rst_WR_DATA", bus.WR_DATA, 0);
      check("rst_RD_ADDR", bus.RD_ADDR, 0);
      check("rst_TX_BYTE", bus.TX_BYTE, 0);
      check("rst_TX_VALID", bus.TX_VALID, 0);
      check("rst_BUSY", bus.BUSY, 0);
`ifdef UART_CMD_PARSER_ERRCNT_EN
      check("rst_ERR_COUNT", bus.ERR_COUNT, 0);
      m_err = 0;
`endif
      m_prev = 1'b0; m_q.delete(); m_gap = 0; m_post = 0; m_resp = 1'b0; m_reply = 8'h00;
    end else begin
      exp_wr = (m_post == 1) && m_frame_ok() && (m_q[1] == 8'h57);
      check("WR_EN", bus.WR_EN, exp_wr);
      if (exp_wr) begin
        check("WR_ADDR", bus.WR_ADDR, m_q[2]);
        check("WR_DATA", bus.WR_DATA, m_q[3]);
      end
      if (m_post > 0 && m_frame_ok() && m_q[1] == 8'h52)
        check("RD_ADDR", bus.RD_ADDR, m_q[2]);
      check("TX_VALID", bus.TX_VALID, m_resp);
      if (m_resp) check("TX_BYTE", bus.TX_BYTE, m_reply);
      check("BUSY", bus.BUSY, (m_q.size() > 0) || m_resp);
`ifdef UART_CMD_PARSER_ERRCNT_EN
      check("ERR_COUNT", bus.ERR_COUNT, m_err);
`endif
      if (bus.WR_EN) begin
        wr_seen++;
        last_wr_addr = 8'(bus.WR_ADDR);
        last_wr_data = bus.WR_DATA;
      end
      if (bus.TX_VALID && bus.TX_READY) tx_log.push_back(bus.TX_BYTE);

      // advance the model by one cycle
      evt    = bus.RECEIVED && !m_prev;
      m_prev = bus.RECEIVED;
      if (m_resp) begin
        if (bus.TX_READY) m_resp = 1'b0;
      end else if (m_post == 1) begin
        if (!m_frame_ok()) begin
`ifdef UART_CMD_PARSER_ERRCNT_EN
          if (m_err < 255) m_err++;
`endif
          m_start_reply(8'h15);
        end else if (m_q[1] == 8'h57) begin
`ifdef UART_CMD_PARSER_ERRCNT_EN
          if (m_q[2] == 8'hFF) m_err = 0;
`endif
          m_start_reply(8'h06);
        end else begin
          m_post = 2;
        end
      end else if (m_post == 2) begin
        m_start_reply(reg_val(m_q[2]));
      end else if (m_q.size() > 0) begin
        if (evt) begin
          m_q.push_back(bus.REC_BYTE);
          m_gap = 0;
          if (m_q.size() == 5) m_post = 1;
        end else if (m_gap == int'(TO)) begin
          m_q.delete();
          m_gap = 0;
`ifdef UART_CMD_PARSER_ERRCNT_EN
          if (m_err < 255) m_err++;
`endif
        end else begin
          m_gap++;
        end
      end else if (evt && bus.REC_BYTE == 8'hA5) begin
        m_q.push_back(8'hA5);
        m_gap = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.TX_READY = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.TX_READY = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // RECEIVED high for 'hold' cycles, then low for 'gap' (>=1) cycles.
  task automatic send_byte(input logic [7:0] b, input int hold = 1, input int gap = 2);
    @(posedge clk); #1;
    bus.REC_BYTE = b;
    bus.RECEIVED = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    bus.RECEIVED = 1'b0;
    repeat (gap - 1) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a,
                            input logic [7:0] d, input logic [7:0] k,
                            input int hold = 1);
    send_byte(8'hA5, hold);
    send_byte(c, hold);
    send_byte(a, hold);
    send_byte(d, hold);
    send_byte(k, hold);
  endtask

  task automatic wait_idle(input int budget = 600);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (!bus.BUSY && !bus.TX_VALID) done = 1'b1;
    end
    if (!done) check("wait_idle_BUSY", bus.BUSY, 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, t0;
    int kind, hold, gap;
    logic [7:0] c, a, d, k, tx_hold;
    bit got_valid;

    bus.REC_BYTE = 8'h00;
    bus.RECEIVED = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Write frame
    w0 = wr_seen; t0 = tx_log.size();
    send_frame(8'h57, 8'h10, 8'h3C, 8'h7B);
    wait_idle();
    check("wr_pulses", wr_seen - w0, 1);
    check("wr_addr_lit", last_wr_addr, 8'h10);
    check("wr_data_lit", last_wr_data, 8'h3C);
    check("wr_tx_count", tx_log.size() - t0, 1);
    check("wr_tx_lit", tx_log[$], 8'h06);
    check("wr_model_lit", m_last_reply, 8'h06);

    // Read frame
    w0 = wr_seen; t0 = tx_log.size();
    send_frame(8'h52, 8'h22, 8'h00, 8'h70);
    wait_idle();
    check("rd_no_write", wr_seen - w0, 0);
    check("rd_tx_lit", tx_log[$], 8'h99);
    check("rd_model_lit", m_last_reply, 8'h99);

    // Bad checksum, bad command
    w0 = wr_seen;
    send_frame(8'h57, 8'h10, 8'h3C, 8'h00);
    wait_idle();
    check("badchk_no_write", wr_seen - w0, 0);
    check("badchk_tx_lit", tx_log[$], 8'h15);
    send_frame(8'h41, 8'h00, 8'h00, 8'h41);
    wait_idle();
    check("badcmd_tx_lit", tx_log[$], 8'h15);
    check("badcmd_model_lit", m_last_reply, 8'h15);

    // Noise bytes and 5-cycle strobes
    w0 = wr_seen; t0 = tx_log.size();
    send_byte(8'h00, 5); send_byte(8'hFF, 5); send_byte(8'h5A, 5);
    send_frame(8'h57, 8'h33, 8'h44, 8'h20, 5);
    wait_idle();
    check("noise_wr_pulses", wr_seen - w0, 1);
    check("noise_wr_addr", last_wr_addr, 8'h33);
    check("noise_wr_data", last_wr_data, 8'h44);
    check("noise_tx_count", tx_log.size() - t0, 1);

    // Timeout mid-frame, then a clean frame
    w0 = wr_seen; t0 = tx_log.size();
    send_byte(8'hA5); send_byte(8'h57, 1, TO + 10);
    @(negedge clk);
    check("timeout_BUSY", bus.BUSY, 0);
    check("timeout_no_tx", tx_log.size() - t0, 0);
    send_frame(8'h57, 8'h10, 8'h3C, 8'h7B);
    wait_idle();
    check("after_timeout_wr", wr_seen - w0, 1);

    // Byte landing exactly on the expiry cycle wins; one cycle later loses
    w0 = wr_seen;
    send_byte(8'hA5); send_byte(8'h57); send_byte(8'h10, 1, TO);
    send_byte(8'h3C); send_byte(8'h7B);
    wait_idle();
    check("limit_gap_wr", wr_seen - w0, 1);
    w0 = wr_seen;
    send_byte(8'hA5); send_byte(8'h57); send_byte(8'h10, 1, TO + 1);
    send_byte(8'h3C); send_byte(8'h7B);
    wait_idle();
    check("over_gap_wr", wr_seen - w0, 0);

    // Backpressure: reply held while a whole frame arrives and is ignored
    w0 = wr_seen; t0 = tx_log.size();
    bp_hold = 1'b1;
    send_frame(8'h57, 8'h44, 8'h55, 8'h46);
    got_valid = 1'b0;
    for (int i = 0; i < 20 && !got_valid; i++) begin
      @(negedge clk);
      got_valid = bus.TX_VALID;
    end
    check("bp_valid_up", bus.TX_VALID, 1);
    tx_hold = bus.TX_BYTE;
    check("bp_tx_lit", tx_hold, 8'h06);
    send_frame(8'h57, 8'h10, 8'h3C, 8'h7B, 1);
    repeat (25) @(posedge clk);
    @(negedge clk);
    check("bp_valid_held", bus.TX_VALID, 1);
    check("bp_byte_held", bus.TX_BYTE, tx_hold);
    bp_hold = 1'b0;
    wait_idle();
    check("bp_one_write", wr_seen - w0, 1);
    check("bp_one_reply", tx_log.size() - t0, 1);

    // Reset after the ADDR byte, then a fresh frame
    w0 = wr_seen;
    send_byte(8'hA5); send_byte(8'h57); send_byte(8'h10);
    pulse_reset();
    @(negedge clk);
    check("rst_mid_BUSY", bus.BUSY, 0);
    check("rst_mid_WR_ADDR", bus.WR_ADDR, 0);
    send_frame(8'h57, 8'h20, 8'h77, 8'h00);
    wait_idle();
    check("rst_then_wr", wr_seen - w0, 1);
    check("rst_then_addr", last_wr_addr, 8'h20);

    // Randomized frames
    for (int f = 0; f < 250; f++) begin
      kind = $urandom_range(0, 9);
      a = 8'($urandom);
      d = 8'($urandom);
      if (kind < 4)      c = 8'h57;
      else if (kind < 7) c = 8'h52;
      else               c = 8'($urandom);
      if (kind == 3) a = 8'hFF;
      k = c ^ a ^ d;
      if (kind == 9) k = k ^ (8'h01 << $urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) send_byte(8'($urandom), 1, $urandom_range(1, 4));
      hold = $urandom_range(1, 3);
      send_byte(8'hA5, hold, $urandom_range(1, 6));
      send_byte(c, hold, $urandom_range(1, 6));
      gap = ($urandom_range(0, 19) == 0) ? $urandom_range(TO - 3, TO + 5) : $urandom_range(1, 6);
      send_byte(a, hold, gap);
      send_byte(d, hold, $urandom_range(1, 6));
      send_byte(k, hold, $urandom_range(1, 6));
      if ($urandom_range(0, 3) != 0) wait_idle();
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
